// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared states, command bytes and column-base table for the display scan path
package disp_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PCMD,
        ST_ADDR,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } disp_state_e;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;
    localparam int         INIT_LEN      = 8;

    function automatic logic [10:0] col_base(input logic [2:0] mode);
        case (mode)
            3'd0:    col_base = 11'd0;
            3'd1:    col_base = 11'd256;
            3'd2:    col_base = 11'd512;
            3'd7:    col_base = 11'd1024;
            default: col_base = 11'd768;
        endcase
    endfunction

    // Per-page command preamble: page select, then column pointer reset low/high nibble
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] page);
        case (idx)
            2'd0:    cmd_byte = CMD_PAGE_BASE | {5'd0, page};
            2'd1:    cmd_byte = CMD_COL_LO;
            default: cmd_byte = CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/disp_init_rom.sv
// rtl/disp_init_rom.sv - combinational power-up command table for the OLED controller
module disp_init_rom (
    input  logic [2:0] addr_i,
    output logic [7:0] data_o
);

    always_comb begin
        case (addr_i)
            3'd0:    data_o = 8'hAE;
            3'd1:    data_o = 8'hD5;
            3'd2:    data_o = 8'h80;
            3'd3:    data_o = 8'hA8;
            3'd4:    data_o = 8'h3F;
            3'd5:    data_o = 8'h8D;
            3'd6:    data_o = 8'h14;
            default: data_o = 8'hAF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - OLED frame scan sequencer: address generation, fetch and byte streaming
// Power-up init sequence is compiled in only when DISP_SCAN_INIT_EN is defined.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int COLS      = 256,
    parameter int FETCH_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  page_mode,
    input  logic        refresh,
    input  logic [7:0]  disp_data,
    output logic [10:0] col_all,
    output logic [2:0]  row_all,
    output logic [7:0]  tx_data,
    output logic        tx_dc,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WW = (FETCH_LAT > 0) ? $clog2(FETCH_LAT + 1) : 1;

`ifdef DISP_SCAN_INIT_EN
    localparam disp_state_e RESET_STATE = ST_INIT;
`else
    localparam disp_state_e RESET_STATE = ST_IDLE;
`endif

    disp_state_e    state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [2:0]     page_q, page_d;
    logic [CW-1:0]  col_idx_q, col_idx_d;
    logic [1:0]     cmd_idx_q, cmd_idx_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [10:0]    col_q, col_d;
    logic [2:0]     row_q, row_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_dc_q, tx_dc_d;
    logic           tx_valid_q, tx_valid_d;
    logic           pending_q, pending_d;
    logic           hs;

    assign hs = tx_valid_q & tx_ready;

`ifdef DISP_SCAN_INIT_EN
    logic [2:0] init_idx_q, init_idx_d;
    logic [2:0] init_addr;
    logic [7:0] init_byte;

    // Look one entry ahead on acceptance so init bytes stream back-to-back
    assign init_addr = init_idx_q + 3'(hs);

    disp_init_rom u_init_rom (
        .addr_i (init_addr),
        .data_o (init_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) init_idx_q <= 3'd0;
        else     init_idx_q <= init_idx_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_STATE;
            mode_q     <= 3'd0;
            page_q     <= 3'd0;
            col_idx_q  <= '0;
            cmd_idx_q  <= 2'd0;
            wait_q     <= '0;
            col_q      <= 11'd0;
            row_q      <= 3'd0;
            tx_data_q  <= 8'd0;
            tx_dc_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            page_q     <= page_d;
            col_idx_q  <= col_idx_d;
            cmd_idx_q  <= cmd_idx_d;
            wait_q     <= wait_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tx_data_q  <= tx_data_d;
            tx_dc_q    <= tx_dc_d;
            tx_valid_q <= tx_valid_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        page_d     = page_q;
        col_idx_d  = col_idx_q;
        cmd_idx_d  = cmd_idx_q;
        wait_d     = wait_q;
        col_d      = col_q;
        row_d      = row_q;
        tx_data_d  = tx_data_q;
        tx_dc_d    = tx_dc_q;
        tx_valid_d = tx_valid_q;
        pending_d  = pending_q | (refresh & (state_q != ST_IDLE));
`ifdef DISP_SCAN_INIT_EN
        init_idx_d = init_idx_q;
`endif
        case (state_q)
`ifdef DISP_SCAN_INIT_EN
            ST_INIT: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_data_d  = init_byte;
                end else if (hs) begin
                    if (init_idx_q == 3'(INIT_LEN - 1)) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        init_idx_d = init_addr;
                        tx_data_d  = init_byte;
                    end
                end
            end
`endif
            ST_IDLE: begin
                if (refresh || pending_q) begin
                    mode_d     = page_mode;
                    page_d     = 3'd0;
                    pending_d  = 1'b0;
                    cmd_idx_d  = 2'd0;
                    tx_valid_d = 1'b1;
                    tx_dc_d    = 1'b0;
                    tx_data_d  = cmd_byte(2'd0, 3'd0);
                    state_d    = ST_PCMD;
                end
            end
            ST_PCMD: begin
                if (hs) begin
                    if (cmd_idx_q == 2'd2) begin
                        tx_valid_d = 1'b0;
                        col_idx_d  = '0;
                        col_d      = col_base(mode_q);
                        row_d      = page_q;
                        state_d    = ST_ADDR;
                    end else begin
                        cmd_idx_d = cmd_idx_q + 2'd1;
                        tx_data_d = cmd_byte(cmd_idx_q + 2'd1, page_q);
                    end
                end
            end
            ST_ADDR: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WW'(FETCH_LAT - 1)) begin
                    tx_data_d  = disp_data;
                    tx_dc_d    = 1'b1;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    if (col_idx_q != CW'(COLS - 1)) begin
                        col_idx_d = col_idx_q + 1'b1;
                        col_d     = col_base(mode_q) + 11'(col_idx_q) + 11'd1;
                        state_d   = ST_ADDR;
                    end else if (page_q != 3'd7) begin
                        page_d     = page_q + 3'd1;
                        cmd_idx_d  = 2'd0;
                        tx_valid_d = 1'b1;
                        tx_dc_d    = 1'b0;
                        tx_data_d  = cmd_byte(2'd0, page_q + 3'd1);
                        state_d    = ST_PCMD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign col_all    = col_q;
    assign row_all    = row_q;
    assign tx_data    = tx_data_q;
    assign tx_dc      = tx_dc_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard bench for disp_scan_ctrl (init, framing, stalls, pending, reset)
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  page_mode = 3'd0;
    logic        refresh = 1'b0;
    logic [7:0]  disp_data = 8'd0;
    logic [10:0] col_all;
    logic [2:0]  row_all;
    logic [7:0]  tx_data;
    logic        tx_dc;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        frame_done;

    typedef struct {
        logic        dc;
        logic [7:0]  data;
        logic        is_data;
        logic [10:0] col;
        logic [2:0]  row;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic ready_rand = 1'b0;
    logic [7:0] rom_next = 8'd0;
    int   base_tbl[8] = '{0, 256, 512, 768, 768, 768, 768, 1024};
    logic [7:0] init_tbl[8] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF};

    disp_scan_ctrl #(.COLS(256), .FETCH_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .page_mode  (page_mode),
        .refresh    (refresh),
        .disp_data  (disp_data),
        .col_all    (col_all),
        .row_all    (row_all),
        .tx_data    (tx_data),
        .tx_dc      (tx_dc),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [10:0] c, input logic [2:0] r);
        return c[7:0] ^ {c[10:8], r, 2'b10};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Synchronous picture ROM: address seen in one cycle appears on disp_data the next
    initial forever begin
        @(negedge clk);
        rom_next = rom_f(col_all, row_all);
        @(posedge clk);
        #1 disp_data = rom_next;
    end

    initial forever begin
        @(posedge clk);
        #1 tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        logic       stall = 1'b0;
        logic [7:0] st_data = 8'd0;
        logic       st_dc = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("stall_valid", int'(tx_valid), 1);
                    check("stall_data", int'(tx_data), int'(st_data));
                    check("stall_dc", int'(tx_dc), int'(st_dc));
                end
                if (tx_valid && tx_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_byte", int'(tx_data), -1);
                    end else begin
                        e = sb.pop_front();
                        check("byte_dc", int'(tx_dc), int'(e.dc));
                        check("byte_data", int'(tx_data), int'(e.data));
                        if (e.is_data) begin
                            check("data_col", int'(col_all), int'(e.col));
                            check("data_row", int'(row_all), int'(e.row));
                        end
                    end
                end
                stall   = tx_valid && !tx_ready;
                st_data = tx_data;
                st_dc   = tx_dc;
                if (frame_done) done_cnt++;
            end
        end
    end

    task automatic push_init();
        for (int i = 0; i < 8; i++) sb.push_back('{1'b0, init_tbl[i], 1'b0, 11'd0, 3'd0});
    endtask

    task automatic push_frame(input int mode);
        logic [10:0] c;
        for (int p = 0; p < 8; p++) begin
            sb.push_back('{1'b0, 8'hB0 | 8'(p), 1'b0, 11'd0, 3'd0});
            sb.push_back('{1'b0, 8'h00, 1'b0, 11'd0, 3'd0});
            sb.push_back('{1'b0, 8'h10, 1'b0, 11'd0, 3'd0});
            for (int k = 0; k < 256; k++) begin
                c = 11'(base_tbl[mode] + k);
                sb.push_back('{1'b1, rom_f(c, 3'(p)), 1'b1, c, 3'(p)});
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col_all"}, int'(col_all), 0);
        check({tag, "_row_all"}, int'(row_all), 0);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_tx_dc"}, int'(tx_dc), 0);
        check({tag, "_tx_valid"}, int'(tx_valid), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
`ifdef DISP_SCAN_INIT_EN
        check({tag, "_busy"}, int'(busy), 1);
`else
        check({tag, "_busy"}, int'(busy), 0);
`endif
    endtask

    task automatic settle_after_reset(input string tag);
        int n = 0;
`ifdef DISP_SCAN_INIT_EN
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_init_drained"}, sb.size(), 0);
        @(posedge clk);
        #1 check({tag, "_busy_after_init"}, int'(busy), 0);
`else
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_busy_idle"}, int'(busy), 0);
        check({tag, "_no_bytes"}, int'(tx_valid), 0);
`endif
    endtask

    task automatic pulse_refresh();
        @(posedge clk);
        #1 refresh = 1'b1;
        @(posedge clk);
        #1 refresh = 1'b0;
    endtask

    task automatic wait_frame_done(input string name);
        int n = 0;
        while (!frame_done && n < 40000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, int'(frame_done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int d0;

        // Reset and optional init replay
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("boot");
`ifdef DISP_SCAN_INIT_EN
        push_init();
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        settle_after_reset("boot");

        // Frame latency at mode 2 with ready tied high
        page_mode = 3'd2;
        push_frame(2);
        d0 = done_cnt;
        @(posedge clk);
        #1 refresh = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 refresh = 1'b0;
            n++;
        end while (!frame_done && n < 20000);
        check("frame_latency", n, 6169);
        check("busy_low_at_done", int'(busy), 0);
        @(posedge clk);
        #1 check("done_single_cycle", int'(frame_done), 0);
        check("done_count_f1", done_cnt - d0, 1);
        check("sb_empty_f1", sb.size(), 0);

        // Random backpressure
        page_mode = 3'd5;
        push_frame(5);
        ready_rand = 1'b1;
        pulse_refresh();
        wait_frame_done("done_rand");
        ready_rand = 1'b0;
        check("sb_empty_rand", sb.size(), 0);

        // Mode change and collapsed refresh requests while busy
        page_mode = 3'd3;
        push_frame(3);
        push_frame(7);
        d0 = done_cnt;
        pulse_refresh();
        repeat (100) @(posedge clk);
        #1 page_mode = 3'd7;
        pulse_refresh();
        repeat (3000) @(posedge clk);
        pulse_refresh();
        wait_frame_done("done_pend_a");
        wait_frame_done("done_pend_b");
        repeat (40) @(posedge clk);
        #1;
        check("pending_frames", done_cnt - d0, 2);
        check("pending_busy_idle", int'(busy), 0);
        check("sb_empty_pend", sb.size(), 0);

        // Reset mid-frame during page 4
        page_mode = 3'd0;
        push_frame(0);
        pulse_refresh();
        n = 0;
        while (row_all != 3'd4 && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_page4", int'(row_all), 4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("midreset");
        sb.delete();
`ifdef DISP_SCAN_INIT_EN
        push_init();
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        settle_after_reset("midreset");

        // Clean frame after the abort
        page_mode = 3'd1;
        push_frame(1);
        pulse_refresh();
        wait_frame_done("done_post_reset");
        check("sb_empty_final", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Frame sequencer for the OLED display path. Generates the `col_all`/`row_all` scan address consumed by the full-screen display mux, samples the returned byte after the fetch latency, and streams command and pixel bytes to the serial byte transmitter over a valid/ready handshake. It sits between the page-mode logic and the display data mux / transmitter pair, and owns power-up init, per-page addressing and frame refresh.

## Interface
Parameters:
- `COLS`, 256: columns streamed per page (display width).
- `FETCH_LAT`, 1: cycles between address change and a valid `disp_data` (the picture ROM is synchronous).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `page_mode`  in  3  screen select, 0–7.
- `refresh`  in  1  single-cycle request to draw one frame.
- `disp_data`  in  8  byte from the display mux for the current address.
- `col_all`  out  11  absolute scan column.
- `row_all`  out  3  scan page.
- `tx_data`  out  8  byte to the transmitter.
- `tx_dc`  out  1  0 = command, 1 = data.
- `tx_valid`  out  1  byte offered.
- `tx_ready`  in  1  transmitter accepts when `tx_valid && tx_ready`.
- `busy`  out  1  high from frame start (or init) until the last byte is accepted.
- `frame_done`  out  1  single-cycle pulse after the last data byte of a frame.

## Operation
- Column base per mode (package table): 0→0, 1→256, 2→512, 3–6→768, 7→1024. `col_all = base + col_idx`, `col_idx` in 0..COLS-1.
- States: INIT, IDLE, PCMD, ADDR, WAIT, SEND, DONE.
- INIT: streams the 8-byte init table AE D5 80 A8 3F 8D 14 AF with `tx_dc=0`, one byte per handshake, then IDLE.
- IDLE: on `refresh`, latches `page_mode` into `mode_q`, clears page to 0, asserts `busy`, goes to PCMD.
- PCMD: sends 3 command bytes `B0|page`, `00`, `10` (`tx_dc=0`), then ADDR with `col_idx=0`.
- ADDR: drives `col_all`/`row_all`, then WAIT. WAIT holds the address for `FETCH_LAT` cycles, then samples `disp_data` into `tx_data` and goes to SEND.
- SEND: `tx_valid=1`, `tx_dc=1`, `tx_data` held until the handshake. On acceptance:
  - `col_idx < COLS-1`: increment, go to ADDR.
  - last column with page < 7: increment page, go to PCMD.
  - last column of page 7: go to DONE.
- DONE: pulses `frame_done` for one cycle, drops `busy`, returns to IDLE.
- Mode change and `refresh` requests:
  - `page_mode` is used only when latched at frame start; a mid-frame mode change never tears the frame.
  - `refresh` arriving while busy (including during INIT) sets a single `pending` flag. IDLE treats `pending` as a request, and it is cleared when the frame starts. Multiple requests while busy collapse into one frame.
- `tx_data`/`tx_dc` never change while `tx_valid && !tx_ready`.

## Timing
- Reset values:
  - `col_all`=0, `row_all`=0, `tx_data`=0, `tx_dc`=0, `tx_valid`=0, `frame_done`=0.
  - `busy`=1 with init compiled in, 0 without.
  - `pending`=0; state is INIT, or IDLE without init.
- Reset mid-frame aborts immediately to those values; no partial byte is completed.
- With `tx_ready` tied high:
  - Each data byte costs 2+FETCH_LAT cycles (ADDR, WAIT×FETCH_LAT, SEND); each command byte costs 1 cycle.
  - Frame at `FETCH_LAT`=1 = 8×(3 + 3×256) = 6168 cycles from the IDLE exit to the final handshake, plus 1 cycle for DONE.
- `frame_done` is asserted the cycle after the final data handshake; `busy` falls in that same cycle.
- `refresh` in the same cycle as a DONE→IDLE transition sets `pending`; the next frame starts from IDLE the following cycle.

## Configuration
- `DISP_SCAN_INIT_EN` defined:
  - INIT state and init table are compiled in; the init sequence runs after every reset.
- Not defined:
  - Reset goes directly to IDLE, and `busy` resets to 0.
  - The init table and the INIT state are absent; an external master owns display init.

## Structure
- Package `disp_pkg`:
  - state enum;
  - command constants (`CMD_PAGE_BASE`=B0, `CMD_COL_LO`=00, `CMD_COL_HI`=10);
  - `INIT_LEN`=8;
  - mode→column-base function.
- Sub-module `disp_init_rom`: 3-bit address → 8-bit init byte, combinational. It is instantiated only under `DISP_SCAN_INIT_EN`.

## Test plan
- Reset with init, `tx_ready`=1 → bytes AE D5 80 A8 3F 8D 14 AF with `tx_dc`=0, then `busy`=0.
- `page_mode`=2, `refresh` → first bytes B0 00 10, first data address `col_all`=512/`row_all`=0. Last address is 767/7; `frame_done` pulses once, 6169 cycles after `refresh`.
- `tx_ready` toggled randomly → `tx_data`/`tx_dc` stable while stalled; scoreboard shows exactly 8×256 data bytes, each equal to `disp_data` modelled with a 1-cycle ROM delay.
- `page_mode` changed 3→7 mid-frame, plus two `refresh` pulses while busy → current frame completes at base 768; exactly one further frame follows at base 1024.
- `rst` asserted during page 4 → all outputs at reset values in the same cycle; init replays.
- Built without `DISP_SCAN_INIT_EN` → after reset `busy`=0 and no bytes until `refresh`; first byte is B0.
